// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode constants, FSM state type and shift-width helper for
//               the multicycle ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Base opcodes, alu_op[3:0] with alu_op[4] = 0
    localparam logic [3:0] c_base_and  = 4'b0000;
    localparam logic [3:0] c_base_or   = 4'b0001;
    localparam logic [3:0] c_base_add  = 4'b0010;
    localparam logic [3:0] c_base_sub  = 4'b0110;
    localparam logic [3:0] c_base_slt  = 4'b0111;
    localparam logic [3:0] c_base_sltu = 4'b1001;
    localparam logic [3:0] c_base_xor  = 4'b1100;
    localparam logic [3:0] c_base_srl  = 4'b1101;
    localparam logic [3:0] c_base_sll  = 4'b1110;
    localparam logic [3:0] c_base_sra  = 4'b1111;

    // M-extension funct3, alu_op[2:0] with alu_op[4] = 1
    localparam logic [2:0] c_m_mul    = 3'b000;
    localparam logic [2:0] c_m_mulh   = 3'b001;
    localparam logic [2:0] c_m_mulhsu = 3'b010;
    localparam logic [2:0] c_m_mulhu  = 3'b011;
    localparam logic [2:0] c_m_div    = 3'b100;
    localparam logic [2:0] c_m_divu   = 3'b101;
    localparam logic [2:0] c_m_rem    = 3'b110;
    localparam logic [2:0] c_m_remu   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int shamt_width(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Radix-2 shift-add multiplier / restoring divider on operand
//               magnitudes, with sign correction applied to the final result.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] div_val;

    always_comb begin
        a_signed = (op == c_m_mulh) || (op == c_m_mulhsu) || (op == c_m_div) || (op == c_m_rem);
        b_signed = (op == c_m_mulh) || (op == c_m_div) || (op == c_m_rem);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
        b_mag    = b_neg ? (~op_b + 1'b1) : op_b;

        mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? dsr_q : {XLEN{1'b0}})};
        div_shift = {acc_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, dsr_q};

        acc_d = acc_q;
        lo_d  = lo_q;
        dsr_d = dsr_q;
        cnt_d = cnt_q;
        run_d = run_q;
        op_d  = op_q;
        neg_d = neg_q;

        if (kill) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start) begin
            op_d  = op;
            acc_d = '0;
            run_d = 1'b1;
            cnt_d = CW'(XLEN - 1);
            // Multiply: lo holds the multiplier, dsr the multiplicand.
            // Divide:   lo holds the dividend/quotient, dsr the divisor.
            if (op[2]) begin
                lo_d  = a_mag;
                dsr_d = b_mag;
                neg_d = op[1] ? a_neg : (a_neg ^ b_neg);
            end else begin
                lo_d  = b_mag;
                dsr_d = a_mag;
                neg_d = a_neg ^ b_neg;
            end
        end else if (run_q) begin
            if (op_q[2]) begin
                // A clear top bit of the difference means no borrow.
                if (!div_diff[XLEN]) begin
                    acc_d = div_diff[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                {acc_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
            end
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            lo_q  <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            op_q  <= '0;
            neg_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            op_q  <= op_d;
            neg_q <= neg_d;
        end
    end

    assign done = run_q && (cnt_q == '0);

    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        div_val  = op_q[1] ? acc_q : lo_q;
        if (op_q[2]) begin
            result = neg_q ? (~div_val + 1'b1) : div_val;
        end else if (op_q == c_m_mul) begin
            result = prod_fix[XLEN-1:0];
        end else begin
            result = prod_fix[2*XLEN-1:XLEN];
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu
// Description : Single-issue ALU with one-cycle base ops and iterative
//               RISC-V M-extension multiply/divide behind a valid/ready FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int EN_MULDIV = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      alu_op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    output logic            busy
);

    localparam int   SHW   = shamt_width(XLEN);
    localparam logic MD_EN = (EN_MULDIV != 0);

    state_e          state_q, state_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic            zero_q, zero_d;

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;
    logic            md_start, md_done;
    logic [XLEN-1:0] md_result;

    assign in_ready  = (state_q == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign shamt     = src2[SHW-1:0];
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign alu_out   = alu_out_q;
    assign zero      = zero_q;

    always_comb begin
        base_res = '0;
        case (alu_op[3:0])
            c_base_and:  base_res = src1 & src2;
            c_base_or:   base_res = src1 | src2;
            c_base_add:  base_res = src1 + src2;
            c_base_sub:  base_res = src1 - src2;
            c_base_slt:  base_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            c_base_sltu: base_res = {{(XLEN-1){1'b0}}, src1 < src2};
            c_base_xor:  base_res = src1 ^ src2;
            c_base_srl:  base_res = src1 >> shamt;
            c_base_sll:  base_res = src1 << shamt;
            c_base_sra:  base_res = XLEN'($signed(src1) >>> shamt);
            default:     base_res = '0;
        endcase
    end

    // Divide corner cases resolve without iterating; alu_op[2] marks divides,
    // alu_op[1] selects remainder, alu_op[0] selects unsigned.
    always_comb begin
        div_zero = (src2 == '0);
        div_ovf  = !alu_op[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
        fast     = !MD_EN || (alu_op[2] && (div_zero || div_ovf));
        if (!MD_EN) begin
            fast_res = '0;
        end else if (div_zero) begin
            fast_res = alu_op[1] ? src1 : '1;
        end else begin
            fast_res = alu_op[1] ? '0 : src1;
        end
    end

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        md_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    zero_d = (src1 == src2);
                    if (!alu_op[4]) begin
                        alu_out_d = base_res;
                        state_d   = DONE;
                    end else if (fast) begin
                        alu_out_d = fast_res;
                        state_d   = DONE;
                    end else begin
                        md_start = 1'b1;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                alu_out_d = md_result;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            alu_out_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
        end
    end

    generate
        if (EN_MULDIV != 0) begin : g_muldiv
            muldiv_unit #(
                .XLEN (XLEN)
            ) u_muldiv (
                .clk    (clk),
                .rst    (rst),
                .start  (md_start),
                .kill   (flush),
                .op     (alu_op[2:0]),
                .op_a   (src1),
                .op_b   (src2),
                .done   (md_done),
                .result (md_result)
            );
        end else begin : g_no_muldiv
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_alu
// Description : Directed self-checking bench for multicycle_alu (XLEN = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

    localparam logic [4:0] ADD = 5'b00010, SUB = 5'b00110, AND = 5'b00000, OR = 5'b00001;
    localparam logic [4:0] SLT = 5'b00111, SLTU = 5'b01001, XOR = 5'b01100, SRL = 5'b01101;
    localparam logic [4:0] SLL = 5'b01110, SRA = 5'b01111, UNDEF = 5'b00011;
    localparam logic [4:0] MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010, MULHU = 5'b10011;
    localparam logic [4:0] DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [4:0]  alu_op = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_out;
    logic        zero;
    logic        busy;

    int passed = 0;
    int total  = 0;

    multicycle_alu #(
        .XLEN      (32),
        .EN_MULDIV (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .alu_op    (alu_op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, scramble the inputs after acceptance, wait for
    // the result, then release it and confirm out_valid drops.
    task automatic exec(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_z, input int exp_lat);
        int lat;
        alu_op   = op;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        src1     = 32'hDEAD_BEEF;
        src2     = 32'h0;
        alu_op   = ADD;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_res"}, alu_out, exp_res);
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_z});
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin : stim
        int seen;
        int bad;

        tick();
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_alu_out", alu_out, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // Base ops
        exec("add",   ADD,   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);
        exec("sra",   SRA,   32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1);
        exec("and",   AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
        exec("or",    OR,    32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1);
        exec("sub",   SUB,   32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 1'b1, 1);
        exec("slt",   SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
        exec("sltu",  SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        exec("xor",   XOR,   32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1);
        exec("srl",   SRL,   32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 1'b0, 1);
        exec("sll",   SLL,   32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1);
        exec("undef", UNDEF, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1);

        // Iterative multiply
        exec("mulh",   MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 34);
        exec("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 34);
        exec("mul",    MUL,    32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 1'b0, 34);
        exec("mul_neg", MUL,   32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 1'b0, 34);
        exec("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 34);

        // Iterative divide
        exec("div",    DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 34);
        exec("rem",    REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 34);
        exec("div_nd", DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34);
        exec("rem_nd", REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
        exec("divu",   DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 34);
        exec("remu",   REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 34);

        // Fast-path corner cases
        exec("div_ovf", DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        exec("rem_ovf", REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1);
        exec("divu_z",  DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1);
        exec("remu_z",  REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, 1);
        exec("div_z",   DIV,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1);
        exec("rem_z",   REM,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b0, 1);

        // Flush of an in-flight MUL in cycle 10
        alu_op   = MUL;
        src1     = 32'd3;
        src2     = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("flush_busy_c10", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_busy_c11", {31'b0, busy}, 32'd0);
        chk("flush_valid_c11", {31'b0, out_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        exec("post_flush_add", ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1);

        // Request coincident with flush is dropped
        alu_op   = ADD;
        src1     = 32'd1;
        src2     = 32'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_accept_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("flush_accept_valid", {31'b0, out_valid}, 32'd0);

        // DONE held with out_ready low; inputs wiggle and must be ignored
        alu_op   = ADD;
        src1     = 32'd10;
        src2     = 32'd20;
        in_valid = 1'b1;
        tick();
        src1   = 32'd99;
        alu_op = SUB;
        bad    = 0;
        repeat (5) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_out !== 32'd30 || zero !== 1'b0) bad++;
            tick();
        end
        chk("hold_bad_cycles", 32'(bad), 32'd0);
        chk("hold_alu_out", alu_out, 32'd30);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset during BUSY; zero was set by equal operands
        alu_op   = MUL;
        src1     = 32'd5;
        src2     = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_alu_out", alu_out, 32'd0);
        chk("rst_mid_zero", {31'b0, zero}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        chk("rst_no_stale", 32'(seen), 32'd0);
        exec("post_rst_add", ADD, 32'd1, 32'd1, 32'd2, 1'b1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; power of two, >= 8.
REQ-002 SHALL have parameter EN_MULDIV, default 1, which enables the M-extension ops; when 0, M opcodes return 0 with base-op latency.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port src1  input  XLEN  operand A.
REQ-008 SHALL have port src2  input  XLEN  operand B.
REQ-009 SHALL have port alu_op  input  5  opcode; bit4=0 base op, bit4=1 M op with bits[2:0] = RISC-V funct3.
REQ-010 SHALL have port flush  input  1  kills any in-flight op.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-013 SHALL have port alu_out  output  XLEN  result.
REQ-014 SHALL have port zero  output  1  registered (src1==src2) of the accepted op.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 Base ops (bit4=0, bits[3:0]) SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed, 1001 SLTU, 1100 XOR, 1101 SRL, 1110 SLL, 1111 SRA; any other code gives 0.
REQ-017 The shift amount SHALL be src2[log2(XLEN)-1:0]; the upper bits of src2 are ignored.
REQ-018 M ops SHALL be: 000 MUL (low XLEN), 001 MULH (s*s), 010 MULHSU (s*u), 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-019 States SHALL be IDLE, BUSY, FIX, DONE; in_ready = (state==IDLE) && !flush.
REQ-020 On accept in IDLE, the block SHALL latch the operands, the opcode and zero.
- Base op: result registered, go to DONE.
- M op: go to BUSY.
REQ-021 BUSY SHALL run XLEN radix-2 iterations on operand magnitudes (shift-add multiply / restoring divide), one per cycle, with a down-counter; at count 0 it SHALL go to FIX.
REQ-022 FIX SHALL apply sign correction (negate product, quotient or remainder per the operand signs), select the result half or field, and go to DONE.
REQ-023 Latency, with acceptance cycle = cycle 0: out_valid SHALL first be high in cycle 1 for base ops and fast-path ops, and in cycle XLEN+2 for iterative M ops.
REQ-024 Divide by zero SHALL take the fast path, with no BUSY:
- DIV/DIVU quotient = all ones.
- REM/REMU = src1.
REQ-025 Signed overflow (src1 = most negative, src2 = -1) SHALL take the fast path: DIV = src1, REM = 0.
REQ-026 In DONE, out_valid SHALL stay high and alu_out/zero SHALL stay stable until out_ready; on out_ready the block SHALL go to IDLE and drop out_valid in the next cycle.
REQ-027 flush in any state SHALL force IDLE at the next edge with out_valid low; an op presented in the same cycle as flush SHALL NOT be accepted.
REQ-028 While not IDLE, in_valid SHALL be ignored and src1/src2/alu_op changes SHALL NOT affect the in-flight op.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, out_valid 0, alu_out 0, zero 0, iteration counter 0 and busy 0.
REQ-030 rst asserted mid-operation SHALL discard the op; after release, the first result SHALL come only from a newly accepted request.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode constants (base and M), the state enum and a function for the shift-amount width.
REQ-032 The iterative multiply/divide datapath SHALL be one sub-module, muldiv_unit (start, op, operands, done, result); base ops and the FSM SHALL stay in multicycle_alu.

Verification
REQ-033 ADD 0x7FFFFFFF+1 -> alu_out 0x80000000, zero 0, out_valid in cycle 1; SRA 0x80000000 by src2=0x24 -> 0xF8000000 (shamt 4).
REQ-034 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; out_valid first high in cycle 34.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1.
REQ-036 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; both out_valid in cycle 1.
REQ-037 MUL accepted, flush in cycle 10 -> IDLE in cycle 11, no out_valid; next ADD 3+4 -> 7.
REQ-038 DONE with out_ready low for 5 cycles -> alu_out held and in_ready 0 throughout; rst pulse during BUSY -> all outputs 0 immediately.
